// File: rtl/rv_buf_pkg.sv
// rv_buf_pkg: shared types and constants for the rv_elastic_buf slice.
// Holds the buffer mode enum, the drop counter width and the pointer width helper.
// Imported by rv_wrap_ctr and rv_elastic_buf.
package rv_buf_pkg;

  typedef enum logic {
    RV_MODE_BACKPRESSURE,
    RV_MODE_OVERWRITE
  } rv_buf_mode_e;

  localparam int RV_DROP_CNT_W = 16;

  // Pointer width for a modulo-depth index; a single-entry buffer still gets one bit
  // so that every port and signal keeps a legal non-zero width.
  function automatic int rv_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv_wrap_ctr.sv
// rv_wrap_ctr: modulo-DEPTH pointer, wraps DEPTH-1 -> 0, synchronous clear has priority.
// Latency: new value visible one cycle after inc/clr.
// Backpressure: none; the caller gates inc.
module rv_wrap_ctr
  import rv_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = rv_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Advance by one per inc, wrapping at the last entry rather than at a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rv_elastic_buf.sv
// rv_elastic_buf: DEPTH-entry in-order ready/valid buffer, backpressure or overwrite-oldest mode.
// Latency: a word accepted at edge N is presented after edge N on an empty buffer (no bypass).
// Backpressure: in_ready = !full from registered count only; overwrite mode holds in_ready at 1 and drops the oldest.
// Build option: define RV_BUF_DROP_CNT_EN to add the drop_cnt port (16-bit saturating overwrite-drop count).
module rv_elastic_buf
  import rv_buf_pkg::*;
#(
  parameter  int           DATA_W = 32,
  parameter  int           DEPTH  = 4,
  parameter  rv_buf_mode_e MODE   = RV_MODE_BACKPRESSURE,
  localparam int           CNT_W  = $clog2(DEPTH + 1),
  localparam int           PTR_W  = rv_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
`ifdef RV_BUF_DROP_CNT_EN
  ,
  output logic [RV_DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is deliberately not reset; out_data is masked while empty instead.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Backpressure mode looks only at registered occupancy, so no out_ready -> in_ready path exists.
  assign in_ready = (MODE == RV_MODE_OVERWRITE) ? 1'b1 : !full;

  // Flush wins over any transfer in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // A drop only happens when full with nobody reading; with a pop it is an ordinary exchange.
  assign drop = (MODE == RV_MODE_OVERWRITE) && full && push && !pop;

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  rv_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  // The read side also steps on a drop so the oldest word is discarded.
  rv_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop || drop),
    .ptr   (rd_ptr)
  );

  // Write the accepted word into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Occupancy: a drop replaces a word, so it leaves count at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (push && !pop && !drop) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef RV_BUF_DROP_CNT_EN
  // Saturating count of overwritten words; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + RV_DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/rv_elastic_buf.md
# rv_elastic_buf

Parametrised multi-entry ready/valid elastic buffer, the next-generation replacement for the single-entry pipeline register stage. Accepts words on an upstream valid/ready channel, stores up to DEPTH of them in order, and presents the oldest on a downstream valid/ready channel. Adds an explicit upstream `in_ready`, selectable backpressure or overwrite-oldest mode, synchronous flush, and an occupancy output.

## Interface
- `DATA_W`, 32, payload width in bits (≥1)
- `DEPTH`, 4, number of storage entries (≥1, any integer, not restricted to powers of two)
- `MODE`, `RV_MODE_BACKPRESSURE`, `rv_buf_mode_e`: backpressure or overwrite-oldest
- `clk` in 1, single clock, all state on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `flush` in 1, synchronous clear of all entries
- `in_valid` in 1, upstream word present
- `in_ready` out 1, buffer accepts a word this cycle
- `in_data` in DATA_W, upstream payload
- `out_valid` out 1, oldest word presented
- `out_ready` in 1, downstream takes the word this cycle
- `out_data` out DATA_W, oldest payload
- `count` out $clog2(DEPTH+1), current occupancy
- `drop_cnt` out 16, words discarded by overwrite (present only with `RV_BUF_DROP_CNT_EN`)

## Operation
- Circular storage with `wr_ptr`, `rd_ptr` wrapping DEPTH-1 → 0, plus a `count` register; storage array is not reset.
- push = `in_valid && in_ready && !flush`; pop = `out_valid && out_ready && !flush`.
- `out_valid` = (count != 0); `out_data` = mem[rd_ptr] when `out_valid`, else 0.
- Backpressure mode: `in_ready` = (count != DEPTH), derived from registered state only; no combinational path from `out_ready` to `in_ready`. When full, simultaneous push+pop is impossible (`in_ready` low).
- Overwrite mode: `in_ready` held 1 (outside reset). Full, push, no pop → oldest entry dropped: `rd_ptr` and `wr_ptr` both advance, new word written, count stays DEPTH, `drop_cnt` increments.
- Full + push + pop in overwrite mode: ordinary push/pop, no drop.
- Push and pop in the same cycle at any non-full occupancy: count unchanged, both pointers advance.
- `flush`: next edge sets pointers and count to 0; overrides any push/pop the same cycle. A flushed push is not counted as a drop. `drop_cnt` is not cleared by flush.
- `drop_cnt` saturates at 16'hFFFF.
- Order is strictly FIFO; no word is duplicated; in backpressure mode, no word is lost.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1, `drop_cnt`=0; pointers 0.
- Reset assertion mid-operation empties the buffer immediately (asynchronously); stored words are lost.
- Latency: a word pushed at edge N is on `out_data` with `out_valid`=1 after edge N when the buffer was empty (one cycle, no bypass).
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- Upstream must hold `in_data` stable while `in_valid` is high and `in_ready` is low. The block holds `out_data` stable while `out_valid` is high and `out_ready` is low, except in overwrite mode on a drop.
- DEPTH=1: backpressure mode alternates accept and present, giving half throughput. Overwrite mode acts as a last-value register, matching the legacy replace behaviour.

## Configuration
- `RV_BUF_DROP_CNT_EN` defined: `drop_cnt` port and its 16-bit saturating counter exist.
- Undefined: port and counter are absent, and overwrite still drops silently.
- Backpressure-mode behaviour is identical either way.

## Structure
- Package `rv_buf_pkg`:
  - `typedef enum logic {RV_MODE_BACKPRESSURE, RV_MODE_OVERWRITE} rv_buf_mode_e`
  - localparam `RV_DROP_CNT_W` = 16
- Sub-module `rv_wrap_ctr`: parametrised modulo-DEPTH pointer with increment and clear inputs, instantiated for `wr_ptr` and `rd_ptr`.

## Test plan
- Reset, then push 32'h1111_1111 with `out_ready`=1 → `out_valid` rises one cycle later with 32'h1111_1111, consumed next cycle, `count` returns 0.
- Backpressure (DEPTH=4): `out_ready`=0, push 32'hA0..32'hA5 → first four accepted, `in_ready`=0 at count=4. Raise `out_ready` → A0..A3 emerge in order; A4 and A5 are accepted only after space frees.
- Overwrite (DEPTH=4): fill with B0..B3, push BB while `out_ready`=0 → out sequence B1,B2,B3,BB; `drop_cnt`=1 with the macro defined.
- Streaming: `in_valid` and `out_ready` held 1 for 100 cycles with incrementing data → every word appears exactly once, in order, `count` ≤1.
- Flush at count=3 with a simultaneous push of 32'hDEAD_BEEF → next cycle `count`=0 and `out_valid`=0; DEAD_BEEF never emerges.
- Assert `rst_n` low mid-stream at count=2 → `out_valid`=0 and `count`=0 before the next clock edge; normal operation resumes after release.
